pipelined_alu_datapath: RTL and testbench

- Parametrised, sequential successor to the register-bank/ALU/memory datapath.
- Accepts one ALU command per valid/ready handshake and reads two operands from an internal register file.
- Computes the result with a MIPS-style ALU, then writes it to the register file or to internal data memory.
- Runs a 4-state FSM and adds a registered zero flag, a done pulse and an operation counter.

---
 rtl/pipelined_alu_datapath.sv | 150 +++++++++++++++
 tb/tb_pipelined_alu_datapath.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu_datapath.sv
// Multi-cycle register-file / ALU / data-memory datapath: one command per valid/ready
// handshake, executed over READ, EXEC and WRITE states, with zero flag, done pulse and op counter.
module pipelined_alu_datapath #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5,
    parameter int MEM_ADDR = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [2:0]          cmdOp,
    input  logic [REG_ADDR-1:0] cmdRs,
    input  logic [REG_ADDR-1:0] cmdRt,
    input  logic                cmdToMem,
    input  logic [REG_ADDR-1:0] cmdRd,
    input  logic [MEM_ADDR-1:0] cmdMemDir,
    input  logic                regWe,
    input  logic [REG_ADDR-1:0] regWdir,
    input  logic [WIDTH-1:0]    regWdata,
    input  logic [MEM_ADDR-1:0] memRdDir,
    output logic [WIDTH-1:0]    memDout,
    output logic [WIDTH-1:0]    result,
    output logic                zf,
    output logic                done,
    output logic [CNT_W-1:0]    opCount
);

    // state   | meaning
    // S_IDLE  | ready; accepts a command and direct register loads
    // S_READ  | operands A/B latched from the register file
    // S_EXEC  | ALU result and zero flag registered
    // S_WRITE | result stored to register or memory, done pulsed
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    localparam int NREG = 2 ** REG_ADDR;
    localparam int NMEM = 2 ** MEM_ADDR;

    state_t state_q, state_d;
    logic   cmd_fire;

    logic [WIDTH-1:0]    rf_q  [NREG];
    logic [WIDTH-1:0]    mem_q [NMEM];
    logic [2:0]          op_q;
    logic [REG_ADDR-1:0] rs_q, rt_q, rd_q;
    logic [MEM_ADDR-1:0] mem_dir_q;
    logic                to_mem_q;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [WIDTH-1:0]    result_q;
    logic                zf_q;
    logic                done_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    rd_a, rd_b, alu_y;

    assign cmdReady = (state_q == S_IDLE);
    assign memDout  = mem_q[memRdDir];
    assign result   = result_q;
    assign zf       = zf_q;
    assign done     = done_q;
    assign opCount  = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cmd_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmdValid) begin
                    cmd_fire = 1'b1;
                    state_d  = S_READ;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // register 0 is hardwired to zero on the read side as well as guarded on writes
    assign rd_a = (rs_q == '0) ? '0 : rf_q[rs_q];
    assign rd_b = (rt_q == '0) ? '0 : rf_q[rt_q];

    always_comb begin
        alu_y = '0;
        case (op_q)
            3'b000:  alu_y = a_q & b_q;
            3'b001:  alu_y = a_q | b_q;
            3'b010:  alu_y = a_q + b_q;
            3'b110:  alu_y = a_q - b_q;
            3'b111:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            for (int i = 0; i < NMEM; i++) mem_q[i] <= '0;
            op_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            mem_dir_q <= '0;
            to_mem_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zf_q      <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (regWe && (regWdir != '0)) rf_q[regWdir] <= regWdata;
                    if (cmd_fire) begin
                        op_q      <= cmdOp;
                        rs_q      <= cmdRs;
                        rt_q      <= cmdRt;
                        rd_q      <= cmdRd;
                        mem_dir_q <= cmdMemDir;
                        to_mem_q  <= cmdToMem;
                    end
                end
                S_READ: begin
                    a_q <= rd_a;
                    b_q <= rd_b;
                end
                S_EXEC: begin
                    result_q <= alu_y;
                    zf_q     <= (alu_y == '0);
                end
                S_WRITE: begin
                    if (to_mem_q)          mem_q[mem_dir_q] <= result_q;
                    else if (rd_q != '0)   rf_q[rd_q]       <= result_q;
                    done_q <= 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_alu_datapath.sv
// Self-checking bench: directed scenarios plus randomized commands compared against a
// transaction-level model of the register file, memory and ALU.
module tb_pipelined_alu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid, cmdReady;
    logic [2:0]  cmdOp;
    logic [4:0]  cmdRs, cmdRt, cmdRd;
    logic        cmdToMem;
    logic [4:0]  cmdMemDir;
    logic        regWe;
    logic [4:0]  regWdir;
    logic [31:0] regWdata;
    logic [4:0]  memRdDir;
    logic [31:0] memDout, result;
    logic        zf, done;
    logic [15:0] opCount;

    pipelined_alu_datapath dut (
        .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdRs(cmdRs), .cmdRt(cmdRt), .cmdToMem(cmdToMem), .cmdRd(cmdRd),
        .cmdMemDir(cmdMemDir), .regWe(regWe), .regWdir(regWdir), .regWdata(regWdata),
        .memRdDir(memRdDir), .memDout(memDout), .result(result), .zf(zf), .done(done),
        .opCount(opCount)
    );

    always #5 clk = ~clk;

    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [32];
    logic [15:0] m_cnt;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
        longint sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
        longint d;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return 32'((ua + ub) % 64'sh1_0000_0000);
            3'd6: begin
                d = ua - ub;
                if (d < 0) d = d + 64'sh1_0000_0000;
                return 32'(d);
            end
            3'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]  = '0;
            m_mem[i] = '0;
        end
        m_cnt = '0;
    endtask

    task automatic load_reg(input logic [4:0] a, input logic [31:0] d);
        regWe = 1'b1; regWdir = a; regWdata = d;
        tick();
        regWe = 1'b0;
        if (a != 0) m_rf[a] = d;
    endtask

    // Issues one command at the current IDLE cycle and follows it through E0..E3.
    task automatic do_cmd(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic to_mem, input logic [4:0] rd, input logic [4:0] md,
                          input logic co_we, input logic [4:0] co_a, input logic [31:0] co_d,
                          input logic poke, input logic [4:0] pk_a, input logic [31:0] pk_d,
                          input logic hold);
        logic [31:0] y;
        cmdValid = 1'b1; cmdOp = op; cmdRs = rs; cmdRt = rt; cmdToMem = to_mem;
        cmdRd = rd; cmdMemDir = md; memRdDir = md;
        regWe = co_we; regWdir = co_a; regWdata = co_d;
        if (co_we && co_a != 0) m_rf[co_a] = co_d;
        y = ref_alu(op, m_rf[rs], m_rf[rt]);
        tick();                                   // E0
        regWe = 1'b0; cmdValid = hold;
        chk("ready_E0", cmdReady, 0);
        chk("done_E0", done, 0);
        if (poke) begin
            regWe = 1'b1; regWdir = pk_a; regWdata = pk_d;
        end
        tick();                                   // E1
        regWe = 1'b0;
        chk("ready_E1", cmdReady, 0);
        tick();                                   // E2
        chk("ready_E2", cmdReady, 0);
        chk("result_E2", result, y);
        chk("zf_E2", zf, (y == 0));
        chk("done_E2", done, 0);
        chk("mem_pre_write", memDout, m_mem[md]);
        tick();                                   // E3
        if (to_mem) m_mem[md] = y;
        else if (rd != 0) m_rf[rd] = y;
        m_cnt = m_cnt + 16'd1;
        chk("done_E3", done, 1);
        chk("ready_E3", cmdReady, 1);
        chk("opcount", opCount, m_cnt);
        chk("result_hold", result, y);
        if (to_mem) chk("mem_write", memDout, y);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic to_mem, input logic [4:0] rd, input logic [4:0] md);
        do_cmd(op, rs, rt, to_mem, rd, md, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cmdValid = 1'b0; cmdOp = '0; cmdRs = '0; cmdRt = '0; cmdToMem = 1'b0;
        cmdRd = '0; cmdMemDir = '0; regWe = 1'b0; regWdir = '0; regWdata = '0; memRdDir = '0;
        model_clear();
        tick(); tick();
        rst = 1'b0;

        // dirty state, then reset
        load_reg(5'd1, 32'h1234); load_reg(5'd2, 32'h55);
        cmd(3'd1, 5'd1, 5'd2, 1'b1, 5'd0, 5'd9);
        cmd(3'd2, 5'd1, 5'd2, 1'b0, 5'd3, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("rst_ready", cmdReady, 1);
        chk("rst_done", done, 0);
        chk("rst_opcount", opCount, 0);
        chk("rst_zf", zf, 0);
        chk("rst_result", result, 0);
        memRdDir = 5'd9; #1;
        chk("rst_mem9", memDout, 0);
        cmd(3'd1, 5'd1, 5'd3, 1'b1, 5'd0, 5'd10);

        // ADD 5+7 to memory, SUB to zero, SLT signed
        m_cnt = opCount;
        load_reg(5'd1, 32'd5); load_reg(5'd2, 32'd7);
        cmd(3'd2, 5'd1, 5'd2, 1'b1, 5'd0, 5'd3);
        cmd(3'd6, 5'd1, 5'd1, 1'b0, 5'd4, 5'd0);
        load_reg(5'd1, 32'hFFFF_FFFF);
        cmd(3'd7, 5'd1, 5'd2, 1'b0, 5'd5, 5'd0);
        cmd(3'd1, 5'd5, 5'd0, 1'b1, 5'd0, 5'd11);
        chk("slt_reg5", memDout, 1);

        // wrap to zero, writes to r0 discarded
        load_reg(5'd2, 32'd1);
        cmd(3'd2, 5'd1, 5'd2, 1'b0, 5'd0, 5'd0);
        load_reg(5'd0, 32'hDEAD_BEEF);
        cmd(3'd1, 5'd0, 5'd0, 1'b1, 5'd0, 5'd12);
        chk("r0_zero", memDout, 0);

        // back-to-back with cmdValid held; regWe during READ ignored
        load_reg(5'd2, 32'd7);
        do_cmd(3'd2, 5'd1, 5'd2, 1'b1, 5'd0, 5'd13, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        do_cmd(3'd0, 5'd2, 5'd2, 1'b0, 5'd6, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hAAAA, 1'b1);
        do_cmd(3'd1, 5'd2, 5'd0, 1'b1, 5'd0, 5'd14, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("poke_ignored", memDout, 7);

        // regWe coinciding with acceptance is seen by READ
        do_cmd(3'd2, 5'd7, 5'd2, 1'b1, 5'd0, 5'd15, 1'b1, 5'd7, 32'd100, 1'b0, 5'd0, 32'd0, 1'b0);

        // randomized commands
        for (int i = 0; i < 40; i++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0: v = 32'hFFFF_FFFF;
                1: v = 32'h8000_0000;
                default: v = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) load_reg(5'($urandom_range(0, 7)), v);
            do_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom, 1'b0);
        end

        // reset during EXEC aborts the memory write
        load_reg(5'd1, 32'd3); load_reg(5'd2, 32'd4);
        cmdValid = 1'b1; cmdOp = 3'd2; cmdRs = 5'd1; cmdRt = 5'd2; cmdToMem = 1'b1;
        cmdMemDir = 5'd6; memRdDir = 5'd6;
        tick();                                   // E0
        cmdValid = 1'b0;
        tick();                                   // E1, now in EXEC
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("abort_ready", cmdReady, 1);
        chk("abort_opcount", opCount, 0);
        chk("abort_result", result, 0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_done", done, 0);
            chk("abort_mem6", memDout, 0);
            tick();
        end
        cmd(3'd1, 5'd1, 5'd2, 1'b1, 5'd0, 5'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
